// File: rtl/bank_mixer.sv
// Per-bank sample capture and sequential saturating mixer feeding pwm_module.
// Sums all bank samples plus optional aux, one term per clock, then clamps.
module bank_mixer #(
    parameter int              NBANKS   = 8,
    parameter int              SAMPLE_W = 16,
    parameter int              PWM_W    = 11,
    parameter logic [SAMPLE_W-1:0] MIDSCALE = 16'h7FFF,
    localparam int             BW       = $clog2(NBANKS)
) (
    input  logic                clk_100MHz,
    input  logic                rst,
    input  logic                data_ready,
    input  logic [BW-1:0]       mem_bank,
    input  logic [SAMPLE_W-1:0] mem_dq_o,
    input  logic [NBANKS-1:0]   playing,
    input  logic [SAMPLE_W-1:0] aux_in,
    input  logic                aux_en,
    input  logic                mix_data,
    output logic [PWM_W-1:0]    pwm_level,
    output logic                pwm_valid,
    output logic                clip,
    output logic                overrun,
    output logic                busy
);

    localparam int IW    = $clog2(NBANKS + 1);
    localparam int ACC_W = SAMPLE_W + 5;
    localparam int SW    = SAMPLE_W + 1;
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MINV = -MAXV - 1;
    localparam logic [PWM_W-1:0] PWM_MID = PWM_W'(1) << (PWM_W - 1);

    typedef enum logic [1:0] {IDLE, ACC, SAT} state_t;

    state_t                   state_q, state_d;
    logic signed [SW-1:0]     ch_q     [NBANKS];
    logic signed [SW-1:0]     ch_d     [NBANKS];
    logic signed [SW-1:0]     shadow_q [NBANKS];
    logic signed [SW-1:0]     shadow_d [NBANKS];
    logic signed [SW-1:0]     shadow_aux_q, shadow_aux_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [PWM_W-1:0]         pwm_level_q, pwm_level_d;
    logic                     pwm_valid_q, pwm_valid_d;
    logic                     clip_q, clip_d;
    logic                     overrun_q, overrun_d;
    logic signed [SW-1:0]     term;
    logic signed [ACC_W-1:0]  clamped;
    logic [SAMPLE_W-1:0]      u;

    // Offset-binary to signed; the extra bit holds the full +/- range.
    function automatic logic signed [SW-1:0] to_signed(input logic [SAMPLE_W-1:0] s);
        return {1'b0, s} - {1'b0, MIDSCALE};
    endfunction

    always_comb begin
        for (int i = 0; i < NBANKS; i++) begin
            ch_d[i] = ch_q[i];
            if (!playing[i])
                ch_d[i] = '0;
            else if (data_ready && mem_bank == BW'(i))
                ch_d[i] = to_signed(mem_dq_o);
        end
    end

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        shadow_aux_d = shadow_aux_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        pwm_level_d  = pwm_level_q;
        pwm_valid_d  = 1'b0;
        clip_d       = 1'b0;
        overrun_d    = mix_data && (state_q != IDLE);
        term         = (idx_q == IW'(NBANKS)) ? shadow_aux_q
                                              : shadow_q[idx_q[BW-1:0]];
        clamped      = acc_q;
        if (acc_q > MAXV)
            clamped = MAXV;
        else if (acc_q < MINV)
            clamped = MINV;
        u = clamped[SAMPLE_W-1:0] ^ {1'b1, {(SAMPLE_W-1){1'b0}}};
        unique case (state_q)
            IDLE: begin
                if (mix_data) begin
                    shadow_d     = ch_q;
                    shadow_aux_d = aux_en ? to_signed(aux_in) : '0;
                    acc_d        = '0;
                    idx_d        = '0;
                    state_d      = ACC;
                end
            end
            ACC: begin
                acc_d = acc_q + {{(ACC_W-SW){term[SW-1]}}, term};
                idx_d = idx_q + 1'b1;
                if (idx_q == IW'(NBANKS))
                    state_d = SAT;
            end
            SAT: begin
                pwm_level_d = u[SAMPLE_W-1 -: PWM_W];
                pwm_valid_d = 1'b1;
                clip_d      = (clamped != acc_q);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shadow_aux_q <= '0;
            acc_q        <= '0;
            idx_q        <= '0;
            pwm_level_q  <= PWM_MID;
            pwm_valid_q  <= 1'b0;
            clip_q       <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < NBANKS; i++) begin
                ch_q[i]     <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            shadow_aux_q <= shadow_aux_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            pwm_level_q  <= pwm_level_d;
            pwm_valid_q  <= pwm_valid_d;
            clip_q       <= clip_d;
            overrun_q    <= overrun_d;
            for (int i = 0; i < NBANKS; i++) begin
                ch_q[i]     <= ch_d[i];
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign pwm_level = pwm_level_q;
    assign pwm_valid = pwm_valid_q;
    assign clip      = clip_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/bank_mixer.md
Name: bank_mixer

Overview:
- Downstream consumer of the memory controller's per-bank read stream.
- Latches the most recent sample of each playing bank as `data_ready` strobes arrive tagged with `mem_bank`.
- On each `mix_data` strobe, sums the bank samples and the live aux input sequentially, saturates the result, and converts it to an 11-bit level for `pwm_module`.
- Replaces the ad-hoc integer mixing in the top level with a deterministic, bounded, clip-reporting datapath.

Parameters:
- NBANKS, 8, number of memory banks; `mem_bank` width is clog2(NBANKS).
- SAMPLE_W, 16, width of stored and aux samples (offset-binary).
- PWM_W, 11, output level width.
- MIDSCALE, 16'h7FFF, offset subtracted from raw samples to get signed values.

Ports:
- `clk_100MHz`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `data_ready`  in  1  one-cycle strobe: `mem_dq_o` holds the sample for `mem_bank`.
- `mem_bank`  in  3  bank index of the current read.
- `mem_dq_o`  in  16  registered read data from RAM.
- `playing`  in  8  per-bank play enable from loop_ctrl.
- `aux_in`  in  16  live XADC sample (offset-binary).
- `aux_en`  in  1  include aux in the mix.
- `mix_data`  in  1  one-cycle strobe at 44.1 kHz: start a mix.
- `pwm_level`  out  11  offset-binary output level to pwm_module.
- `pwm_valid`  out  1  one-cycle strobe: `pwm_level` updated.
- `clip`  out  1  one-cycle strobe with `pwm_valid` when saturation occurred.
- `overrun`  out  1  one-cycle strobe: `mix_data` arrived while busy.
- `busy`  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (async, immediate):
  - All `ch_reg`, shadow registers and the accumulator = 0.
  - FSM = IDLE.
  - `pwm_level` = 11'h400 (midscale).
  - `pwm_valid`, `clip`, `overrun`, `busy` = 0.
- Capture stage, every clock, independent of the FSM:
  - On `data_ready` with `playing[mem_bank]` = 1: `ch_reg[mem_bank]` <= `mem_dq_o` - MIDSCALE, as a 17-bit signed value.
  - On `data_ready` with `playing[mem_bank]` = 0: `ch_reg[mem_bank]` <= 0.
  - Any bank whose `playing` bit is 0 is forced to 0 on every clock, so a stopped bank contributes silence within 1 cycle.
  - `mem_bank` >= NBANKS: ignored.
- FSM states:
  - IDLE:
    - On `mix_data` at edge N: `shadow[i]` <= `ch_reg[i]` for all i.
    - `shadow_aux` <= `aux_en` ? `aux_in` - MIDSCALE : 0.
    - acc <= 0, idx <= 0, go to ACC.
  - ACC (edges N+1 .. N+NBANKS+1):
    - acc <= acc + `shadow[idx]` for idx 0..NBANKS-1, then acc <= acc + `shadow_aux` at idx = NBANKS.
    - One term per clock, 9 clocks total.
    - After the aux term, go to SAT.
  - SAT (edge N+NBANKS+2, i.e. N+10):
    - Clamp acc to [-32768, +32767].
    - u = clamped + 32768 (16-bit unsigned).
    - `pwm_level` <= u[15:5].
    - `pwm_valid` <= 1; `clip` <= 1 if the clamp changed the value.
    - Return to IDLE.
- Arithmetic widths:
  - acc is 21-bit signed, sufficient for 9 × ±32768 with no internal overflow.
  - Saturation is applied only once, at SAT.
- Latency: `pwm_valid` is high in the cycle following edge N+10, i.e. exactly 10 clocks after `mix_data` is sampled. `pwm_level` then holds until the next mix.
- `busy` is high from edge N until the FSM returns to IDLE.
- `mix_data` while not IDLE:
  - The strobe is ignored; the in-flight mix is unaffected.
  - `overrun` pulses for 1 cycle.
- Simultaneous `data_ready` and `mix_data` in IDLE: the snapshot takes the pre-update `ch_reg` value. The new sample appears in the next mix.
- `data_ready` during ACC/SAT updates `ch_reg` only; shadows are unaffected.
- Reset mid-mix: abort immediately, with no `pwm_valid` pulse. Outputs return to reset values.

Test Plan:
- Single bank:
  - Stimulus: `playing` = 8'h01, `data_ready` with bank 0 and `mem_dq_o` = 16'h8FFF, `aux_en` = 0, then `mix_data`.
  - Required: `pwm_valid` 10 clocks later, `pwm_level` = 11'h480, `clip` = 0.
- Masking:
  - Stimulus: `playing` = 8'h00, bank 3 written with 16'hFFFF, then `mix_data`.
  - Required: `pwm_level` = 11'h400; with `aux_en` = 1 and `aux_in` = 16'h7FFF, still 11'h400.
- Positive clip:
  - Stimulus: all 8 banks playing, each loaded with 16'hFFFF.
  - Required: `pwm_level` = 11'h7FF with `clip` = 1 on the same cycle as `pwm_valid`.
- Negative clip:
  - Stimulus: banks 0 and 1 playing, loaded with 16'h0000 (sum -65534).
  - Required: `pwm_level` = 11'h000, `clip` = 1.
- Overrun and simultaneity:
  - Stimulus: `mix_data` again 4 cycles after the first.
  - Required: `overrun` pulse, a single `pwm_valid`.
  - Stimulus: `data_ready` on bank 0 coincident with `mix_data`.
  - Required: the old value is used in that mix and the new value in the next.
- Reset mid-mix:
  - Stimulus: assert `rst` at cycle 5 of a mix.
  - Required: `busy` = 0, `pwm_level` = 11'h400, no `pwm_valid`; the next mix after release behaves normally.
